branch_reservation_station: RTL and testbench
=============================================

// Module: branch_reservation_station
// PURPOSE
//  Holds dispatched JALR/B_TYPE ops until both operands are valid, then issues the oldest ready op to the branch FU.
//  Upstream end of the FU ready_to_execute/accept handshake.
//  Operands not ready at dispatch are captured by snooping the CDB. JAL never enters the station.
// PARAMETERS
//  XLEN           32  datapath width
//  ROB_TAG_WIDTH  5   ROB tag width
//  RS_DEPTH       4   entries (>=2)
// PORTS
//  clk                         in   1       clock
//  reset                       in   1       synchronous, active-high
//  flush                       in   1       discard all entries (mispredict recovery)
//  dispatch_valid              in   1       new op presented
//  dispatch_ready              out  1       space available
//  d_v1/d_v2                   in   XLEN    operand values (d_v2 = immediate for JALR)
//  d_q1_wait/d_q2_wait         in   1       operand still pending on ROB tag
//  d_q1/d_q2                   in   RTW     producer ROB tags
//  d_pc/d_immediate/d_pred     in   XLEN    pc, B_TYPE offset, predicted_next_instruction
//  d_rob_tag                   in   RTW     op's own ROB tag
//  d_funct3                    in   3       branch condition
//  d_instruction_length        in   1       1 = 32-bit, 0 = 16-bit
//  d_jalr/d_branch             in   1       op kind (exactly one set)
//  cdb_valid                   in   1       result broadcast
//  cdb_rob_tag                 in   RTW     tag of result
//  cdb_data                    in   XLEN    result value
//  v1/v2/pc/immediate          out  XLEN    to FU
//  predicted_next_instruction  out  XLEN    to FU
//  rob_tag_in                  out  RTW     to FU
//  funct3                      out  3       to FU
//  instruction_length/jalr/branch  out  1   to FU
//  ready_to_execute            out  1       issue request
//  accept                      in   1       FU takes op this cycle
// BEHAVIOUR
//  Storage: collapsing queue in dispatch order; index 0 = oldest. count in 0..RS_DEPTH.
//  - reset: count=0, all entries invalid, ready_to_execute=0, all FU outputs 0, dispatch_ready=0 while reset high.
//  - dispatch_ready = (count < RS_DEPTH) & ~flush. Combinational from registered count only; a same-cycle issue never frees space for a same-cycle dispatch.
//  - Dispatch: dispatch_valid & dispatch_ready appends at tail (after collapse if an issue fires this cycle). dispatch_valid while not ready is ignored (no error).
//  - Dispatch-cycle capture: if d_qN_wait & cdb_valid & cdb_rob_tag==d_qN, store cdb_data and clear wait.
//  - Wakeup: every valid waiting entry compares qN to cdb_rob_tag each cycle; on match, store cdb_data and clear wait. Both operands may wake on the same broadcast.
//  - Ready = valid & ~q1_wait & ~q2_wait.
//  - Select: lowest-index ready entry. ready_to_execute=1 iff any ready; FU outputs = that entry's fields, else 0.
//  - Issue: ready_to_execute & accept at posedge removes the selected entry; younger entries shift down one; count decrements.
//    - accept low: nothing removed, selection may change next cycle.
//    - Simultaneous issue+dispatch: count unchanged.
//  - flush: at posedge count=0, all entries cleared. Dispatch and issue in that cycle are dropped, but the FU has already sampled the issued op combinationally; the ROB discards its result.
//  - Priority: reset > flush > issue/dispatch/wakeup.
//  - Tag widths: all compares are full ROB_TAG_WIDTH equality. No tag aging/wrap handling: the ROB guarantees unique live tags.
// CONFIGURATION
//  BRS_WAKEUP_BYPASS_EN defined:
//   - Readiness also counts an operand matching this cycle's CDB; issue fields mux cdb_data in.
//   - An op can issue the same cycle its last operand is broadcast.
//  Not defined:
//   - Readiness uses stored state only; such an op issues no earlier than the next cycle.
//   - No CDB-to-FU combinational path.
// TESTING
//  1. Reset, then dispatch BEQ v1=5 v2=5 no waits, accept=1 -> ready_to_execute=1 next cycle, funct3=000, v1=v2=5, count returns 0.
//  2. Dispatch JALR q1=3 wait, d_v2=8; CDB tag 3 data 0x100 two cycles later -> issue with v1=0x100, v2=8:
//     same cycle as CDB with BRS_WAKEUP_BYPASS_EN, one cycle later without.
//  3. Fill 4 entries, all waiting -> dispatch_ready=0; 5th dispatch ignored; wake entry 2 -> it issues first, entries 3 shift to index 2, dispatch_ready=1 after.
//  4. Entries 0 and 1 both ready -> entry 0 (older rob_tag) issues first, entry 1 next cycle.
//  5. Dispatch with d_q1=7 wait while CDB broadcasts tag 7 data 0xAB that cycle -> entry stored v1=0xAB ready, no hang.
//  6. Three entries, flush=1 with dispatch_valid=1 -> count=0 next cycle, ready_to_execute=0, new op not stored; reset mid-fill gives identical result.

Source files
------------

// File: rtl/branch_reservation_station.sv
// Branch reservation station: holds dispatched JALR / B_TYPE ops in a
// collapsing age-ordered queue (index 0 = oldest) until both operands are
// available, then offers the oldest ready op to the branch FU.
//
// Optional feature macro: BRS_WAKEUP_BYPASS_EN
//   defined     -> an operand broadcast on the CDB this cycle counts as ready
//                  and cdb_data is muxed straight onto the FU operand outputs.
//   not defined -> readiness comes from stored state only (no CDB-to-FU path).
//
// Handshakes:
//   dispatch: an op is taken at posedge when dispatch_valid & dispatch_ready.
//             dispatch_ready depends only on registered occupancy, flush and
//             reset, never on dispatch_valid or same-cycle issue.
//   issue:    ready_to_execute is asserted while any entry is ready; the
//             selected op is removed at posedge when ready_to_execute & accept.
//             Outputs may change while accept is low.
module branch_reservation_station #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int RS_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [XLEN-1:0]          d_v1,
  input  logic [XLEN-1:0]          d_v2,
  input  logic                     d_q1_wait,
  input  logic                     d_q2_wait,
  input  logic [ROB_TAG_WIDTH-1:0] d_q1,
  input  logic [ROB_TAG_WIDTH-1:0] d_q2,
  input  logic [XLEN-1:0]          d_pc,
  input  logic [XLEN-1:0]          d_immediate,
  input  logic [XLEN-1:0]          d_pred,
  input  logic [ROB_TAG_WIDTH-1:0] d_rob_tag,
  input  logic [2:0]               d_funct3,
  input  logic                     d_instruction_length,
  input  logic                     d_jalr,
  input  logic                     d_branch,
  input  logic                     cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic [XLEN-1:0]          v1,
  output logic [XLEN-1:0]          v2,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          immediate,
  output logic [XLEN-1:0]          predicted_next_instruction,
  output logic [ROB_TAG_WIDTH-1:0] rob_tag_in,
  output logic [2:0]               funct3,
  output logic                     instruction_length,
  output logic                     jalr,
  output logic                     branch,
  output logic                     ready_to_execute,
  input  logic                     accept
);

  localparam int IDXW = $clog2(RS_DEPTH);
  localparam int CW   = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]          v1;
    logic [XLEN-1:0]          v2;
    logic                     q1_wait;
    logic                     q2_wait;
    logic [ROB_TAG_WIDTH-1:0] q1;
    logic [ROB_TAG_WIDTH-1:0] q2;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          immediate;
    logic [XLEN-1:0]          pred;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic [2:0]               funct3;
    logic                     instruction_length;
    logic                     jalr;
    logic                     branch;
  } entry_t;

  entry_t              ent     [RS_DEPTH];
  entry_t              ent_nxt [RS_DEPTH];
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [CW-1:0]       tail;
  logic [RS_DEPTH-1:0] hit1;
  logic [RS_DEPTH-1:0] hit2;
  logic [RS_DEPTH-1:0] rdy;
  logic                any_ready;
  logic [IDXW-1:0]     sel_idx;
  entry_t              sel;
  entry_t              new_ent;
  logic                issue_fire;
  logic                disp_fire;

  // Space check uses registered occupancy only; blocked during flush/reset.
  assign dispatch_ready = (count < CW'(RS_DEPTH)) & ~flush & ~reset;
  assign disp_fire      = dispatch_valid & dispatch_ready;
  assign issue_fire     = any_ready & accept;
  assign sel            = ent[sel_idx];

  // Per-entry CDB tag matches and readiness (bypass counts a live match).
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    rdy  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      hit1[i] = cdb_valid & (ent[i].q1 == cdb_rob_tag);
      hit2[i] = cdb_valid & (ent[i].q2 == cdb_rob_tag);
`ifdef BRS_WAKEUP_BYPASS_EN
      rdy[i]  = (CW'(i) < count) & (~ent[i].q1_wait | hit1[i])
                                 & (~ent[i].q2_wait | hit2[i]);
`else
      rdy[i]  = (CW'(i) < count) & ~ent[i].q1_wait & ~ent[i].q2_wait;
`endif
    end
  end

  // Oldest-first select: scan from youngest so the lowest ready index wins.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  // FU outputs: selected entry's fields, zero when nothing is ready.
  always_comb begin
    ready_to_execute           = any_ready;
    v1                         = '0;
    v2                         = '0;
    pc                         = '0;
    immediate                  = '0;
    predicted_next_instruction = '0;
    rob_tag_in                 = '0;
    funct3                     = '0;
    instruction_length         = 1'b0;
    jalr                       = 1'b0;
    branch                     = 1'b0;
    if (any_ready) begin
      v1                         = sel.v1;
      v2                         = sel.v2;
      pc                         = sel.pc;
      immediate                  = sel.immediate;
      predicted_next_instruction = sel.pred;
      rob_tag_in                 = sel.rob_tag;
      funct3                     = sel.funct3;
      instruction_length         = sel.instruction_length;
      jalr                       = sel.jalr;
      branch                     = sel.branch;
`ifdef BRS_WAKEUP_BYPASS_EN
      // A still-waiting operand on a ready entry can only be this cycle's CDB.
      if (sel.q1_wait) v1 = cdb_data;
      if (sel.q2_wait) v2 = cdb_data;
`endif
    end
  end

  // Incoming op with dispatch-cycle CDB capture.
  always_comb begin
    new_ent                    = '0;
    new_ent.v1                 = d_v1;
    new_ent.v2                 = d_v2;
    new_ent.q1_wait            = d_q1_wait;
    new_ent.q2_wait            = d_q2_wait;
    new_ent.q1                 = d_q1;
    new_ent.q2                 = d_q2;
    new_ent.pc                 = d_pc;
    new_ent.immediate          = d_immediate;
    new_ent.pred               = d_pred;
    new_ent.rob_tag            = d_rob_tag;
    new_ent.funct3             = d_funct3;
    new_ent.instruction_length = d_instruction_length;
    new_ent.jalr               = d_jalr;
    new_ent.branch             = d_branch;
    if (d_q1_wait && cdb_valid && (d_q1 == cdb_rob_tag)) begin
      new_ent.v1      = cdb_data;
      new_ent.q1_wait = 1'b0;
    end
    if (d_q2_wait && cdb_valid && (d_q2 == cdb_rob_tag)) begin
      new_ent.v2      = cdb_data;
      new_ent.q2_wait = 1'b0;
    end
  end

  // Next queue contents: wakeup, then collapse the issued slot, then append.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].q1_wait && hit1[i]) begin
        ent_nxt[i].v1      = cdb_data;
        ent_nxt[i].q1_wait = 1'b0;
      end
      if (ent[i].q2_wait && hit2[i]) begin
        ent_nxt[i].v2      = cdb_data;
        ent_nxt[i].q2_wait = 1'b0;
      end
    end
    if (issue_fire) begin
      for (int i = 0; i < RS_DEPTH - 1; i++) begin
        if (IDXW'(i) >= sel_idx) ent_nxt[i] = ent_nxt[i + 1];
      end
      ent_nxt[RS_DEPTH - 1] = '0;
    end
    tail      = count - CW'(issue_fire);
    count_nxt = tail;
    if (disp_fire) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (CW'(i) == tail) ent_nxt[i] = new_ent;
      end
      count_nxt = tail + CW'(1);
    end
  end

  // State register: reset and flush both empty the station.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= ent_nxt[i];
    end
  end

endmodule

// File: tb/tb_branch_reservation_station.sv
// Bench for branch_reservation_station: directed scenarios followed by a
// randomized run checked against a queue-based reference model.
module tb_branch_reservation_station;

  localparam int XLEN  = 32;
  localparam int RTW   = 5;
  localparam int DEPTH = 4;
  localparam int FUW   = 5 * XLEN + RTW + 6;
`ifdef BRS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, flush, dispatch_valid, dispatch_ready;
  logic [XLEN-1:0] d_v1, d_v2, d_pc, d_immediate, d_pred;
  logic            d_q1_wait, d_q2_wait;
  logic [RTW-1:0]  d_q1, d_q2, d_rob_tag;
  logic [2:0]      d_funct3;
  logic            d_instruction_length, d_jalr, d_branch;
  logic            cdb_valid;
  logic [RTW-1:0]  cdb_rob_tag;
  logic [XLEN-1:0] cdb_data;
  logic [XLEN-1:0] v1, v2, pc, immediate, predicted_next_instruction;
  logic [RTW-1:0]  rob_tag_in;
  logic [2:0]      funct3;
  logic            instruction_length, jalr, branch, ready_to_execute, accept;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [XLEN-1:0] v1, v2, pc, imm, pred;
    logic [RTW-1:0]  q1, q2, tag;
    bit              w1, w2;
    logic [2:0]      f3;
    bit              il, j, b;
  } op_t;
  op_t rs_q[$];

  branch_reservation_station #(.XLEN(XLEN), .ROB_TAG_WIDTH(RTW), .RS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .d_v1(d_v1), .d_v2(d_v2), .d_q1_wait(d_q1_wait), .d_q2_wait(d_q2_wait),
    .d_q1(d_q1), .d_q2(d_q2), .d_pc(d_pc), .d_immediate(d_immediate), .d_pred(d_pred),
    .d_rob_tag(d_rob_tag), .d_funct3(d_funct3), .d_instruction_length(d_instruction_length),
    .d_jalr(d_jalr), .d_branch(d_branch),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data),
    .v1(v1), .v2(v2), .pc(pc), .immediate(immediate),
    .predicted_next_instruction(predicted_next_instruction),
    .rob_tag_in(rob_tag_in), .funct3(funct3), .instruction_length(instruction_length),
    .jalr(jalr), .branch(branch), .ready_to_execute(ready_to_execute), .accept(accept)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    dispatch_valid = 1'b0; d_v1 = '0; d_v2 = '0; d_q1_wait = 1'b0; d_q2_wait = 1'b0;
    d_q1 = '0; d_q2 = '0; d_pc = '0; d_immediate = '0; d_pred = '0; d_rob_tag = '0;
    d_funct3 = '0; d_instruction_length = 1'b0; d_jalr = 1'b0; d_branch = 1'b0;
    cdb_valid = 1'b0; cdb_rob_tag = '0; cdb_data = '0;
  endtask

  task automatic drive_dispatch(input logic [RTW-1:0] tag, input logic [2:0] f3,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input bit w1, input logic [RTW-1:0] q1,
                                input bit w2, input logic [RTW-1:0] q2, input bit is_jalr);
    dispatch_valid = 1'b1; d_rob_tag = tag; d_funct3 = f3; d_v1 = a; d_v2 = b;
    d_q1_wait = w1; d_q1 = q1; d_q2_wait = w2; d_q2 = q2;
    d_pc = {tag, 2'b00} + 32'h1000; d_immediate = 32'h40 + 32'(tag);
    d_pred = 32'h2000 + 32'(tag); d_instruction_length = 1'b1;
    d_jalr = is_jalr; d_branch = ~is_jalr;
  endtask

  task automatic drive_cdb(input logic [RTW-1:0] tag, input logic [XLEN-1:0] data);
    cdb_valid = 1'b1; cdb_rob_tag = tag; cdb_data = data;
  endtask

  function automatic logic [FUW-1:0] fu_bundle();
    return {v1, v2, pc, immediate, predicted_next_instruction, rob_tag_in, funct3,
            instruction_length, jalr, branch};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; accept = 1'b0;
    drive_idle();
    drive_dispatch(5'd1, 3'd0, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(); step();
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL reset_dr got=%b exp=0", dispatch_ready); end
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL reset_rte got=%b exp=0", ready_to_execute); end
    checks++; if (fu_bundle() !== '0) begin errors++; $display("FAIL reset_fu got=%h exp=0", fu_bundle()); end
    reset = 1'b0; drive_idle(); #1;
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL post_reset_dr got=%b exp=1", dispatch_ready); end
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL post_reset_rte got=%b exp=0", ready_to_execute); end
  endtask

  task automatic test_beq();
    accept = 1'b1;
    drive_dispatch(5'd1, 3'b000, 32'd5, 32'd5, 1'b0, '0, 1'b0, '0, 1'b0);
    step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b1) begin errors++; $display("FAIL beq_rte got=%b exp=1", ready_to_execute); end
    checks++; if ({v1, v2, funct3, branch, jalr, rob_tag_in} !== {32'd5, 32'd5, 3'b000, 1'b1, 1'b0, 5'd1}) begin
      errors++; $display("FAIL beq_fields got v1=%h v2=%h f3=%b br=%b jalr=%b tag=%0d", v1, v2, funct3, branch, jalr, rob_tag_in);
    end
    checks++; if (pc !== 32'h1004 || immediate !== 32'h41 || predicted_next_instruction !== 32'h2001) begin
      errors++; $display("FAIL beq_pc got pc=%h imm=%h pred=%h exp 1004/41/2001", pc, immediate, predicted_next_instruction);
    end
    step();
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL beq_drain got=%b exp=0", ready_to_execute); end
  endtask

  task automatic test_jalr_wakeup();
    accept = 1'b1;
    drive_dispatch(5'd2, 3'b000, 32'hDEAD, 32'd8, 1'b1, 5'd3, 1'b0, '0, 1'b1);
    step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL jalr_wait1 got=%b exp=0", ready_to_execute); end
    step();
    drive_cdb(5'd3, 32'h100); #1;
    checks++; if (ready_to_execute !== BYP) begin errors++; $display("FAIL jalr_cdb_cycle got=%b exp=%b", ready_to_execute, BYP); end
    step(); drive_idle(); #1;
    if (!BYP) begin
      checks++; if (ready_to_execute !== 1'b1 || v1 !== 32'h100 || v2 !== 32'd8 || jalr !== 1'b1) begin
        errors++; $display("FAIL jalr_issue got rte=%b v1=%h v2=%h jalr=%b exp 1/100/8/1", ready_to_execute, v1, v2, jalr);
      end
      step();
    end
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL jalr_drain got=%b exp=0", ready_to_execute); end
  endtask

  task automatic test_full();
    accept = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_dispatch(5'(10 + i), 3'(i), 32'(i), 32'(i), 1'b1, 5'(20 + i), 1'b0, '0, 1'b0);
      #1;
      checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_dr_%0d got=%b exp=1", i, dispatch_ready); end
      step();
    end
    drive_dispatch(5'd14, 3'd7, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0, 1'b0); #1;
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_dr got=%b exp=0", dispatch_ready); end
    step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL full_5th_ignored got=%b exp=0", ready_to_execute); end
    drive_cdb(5'd22, 32'hC0DE); step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b1 || rob_tag_in !== 5'd12 || v1 !== 32'hC0DE) begin
      errors++; $display("FAIL full_wake2 got rte=%b tag=%0d v1=%h exp 1/12/c0de", ready_to_execute, rob_tag_in, v1);
    end
    accept = 1'b1; step(); accept = 1'b0; #1;
    checks++; if (dispatch_ready !== 1'b1 || ready_to_execute !== 1'b0) begin
      errors++; $display("FAIL full_after_issue got dr=%b rte=%b exp 1/0", dispatch_ready, ready_to_execute);
    end
    drive_cdb(5'd23, 32'hBEEF); step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b1 || rob_tag_in !== 5'd13 || funct3 !== 3'd3) begin
      errors++; $display("FAIL full_shift got rte=%b tag=%0d f3=%0d exp 1/13/3", ready_to_execute, rob_tag_in, funct3);
    end
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_age();
    accept = 1'b0;
    drive_dispatch(5'd4, 3'd1, 32'h44, 32'h1, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive_dispatch(5'd5, 3'd4, 32'h55, 32'h2, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b1 || rob_tag_in !== 5'd4 || v1 !== 32'h44) begin
      errors++; $display("FAIL age_first got rte=%b tag=%0d v1=%h exp 1/4/44", ready_to_execute, rob_tag_in, v1);
    end
    accept = 1'b1; step();
    checks++; if (ready_to_execute !== 1'b1 || rob_tag_in !== 5'd5 || funct3 !== 3'd4) begin
      errors++; $display("FAIL age_second got rte=%b tag=%0d f3=%0d exp 1/5/4", ready_to_execute, rob_tag_in, funct3);
    end
    step();
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL age_drain got=%b exp=0", ready_to_execute); end
    accept = 1'b0;
  endtask

  task automatic test_dispatch_capture();
    accept = 1'b0;
    drive_dispatch(5'd6, 3'd5, 32'h55, 32'h9, 1'b1, 5'd7, 1'b0, '0, 1'b0);
    drive_cdb(5'd7, 32'hAB);
    step(); drive_idle(); #1;
    checks++; if (ready_to_execute !== 1'b1 || v1 !== 32'hAB || rob_tag_in !== 5'd6) begin
      errors++; $display("FAIL capture got rte=%b v1=%h tag=%0d exp 1/ab/6", ready_to_execute, v1, rob_tag_in);
    end
    accept = 1'b1; step(); accept = 1'b0;
    checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL capture_drain got=%b exp=0", ready_to_execute); end
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
        drive_dispatch(5'(1 + i), 3'd0, '0, '0, 1'b1, 5'd9, 1'b0, '0, 1'b0); step();
      end
      drive_dispatch(5'd8, 3'd0, 32'h88, '0, 1'b0, '0, 1'b0, '0, 1'b0);
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      #1;
      checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL flush_dr_%0d got=%b exp=0", pass, dispatch_ready); end
      step(); flush = 1'b0; reset = 1'b0; drive_idle(); #1;
      checks++; if (ready_to_execute !== 1'b0 || dispatch_ready !== 1'b1) begin
        errors++; $display("FAIL flush_empty_%0d got rte=%b dr=%b exp 0/1", pass, ready_to_execute, dispatch_ready);
      end
      drive_cdb(5'd9, 32'h99); step(); drive_idle(); #1;
      checks++; if (ready_to_execute !== 1'b0) begin errors++; $display("FAIL flush_cleared_%0d got=%b exp=0", pass, ready_to_execute); end
    end
  endtask

  task automatic test_random();
    op_t op;
    int sel;
    bit  exp_dr, w1, w2;
    logic [FUW-1:0] exp_fu;
    rs_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_idle();
      flush  = ($urandom_range(0, 19) == 0);
      accept = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        drive_dispatch(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      d_instruction_length = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) drive_cdb(5'($urandom_range(0, 7)), $urandom);
      #1;
      // Expected outputs from the model state and this cycle's inputs.
      exp_dr = (rs_q.size() < DEPTH) && !flush;
      sel = -1;
      for (int i = 0; i < rs_q.size(); i++) begin
        w1 = rs_q[i].w1 && !(BYP && cdb_valid && cdb_rob_tag == rs_q[i].q1);
        w2 = rs_q[i].w2 && !(BYP && cdb_valid && cdb_rob_tag == rs_q[i].q2);
        if (sel < 0 && !w1 && !w2) sel = i;
      end
      exp_fu = '0;
      if (sel >= 0) begin
        op = rs_q[sel];
        if (op.w1) op.v1 = cdb_data;
        if (op.w2) op.v2 = cdb_data;
        exp_fu = {op.v1, op.v2, op.pc, op.imm, op.pred, op.tag, op.f3, op.il, op.j, op.b};
      end
      checks++; if (dispatch_ready !== exp_dr) begin errors++; $display("FAIL rand_dr cyc=%0d got=%b exp=%b", cyc, dispatch_ready, exp_dr); end
      checks++; if (ready_to_execute !== (sel >= 0)) begin errors++; $display("FAIL rand_rte cyc=%0d got=%b exp=%b", cyc, ready_to_execute, sel >= 0); end
      checks++; if (fu_bundle() !== exp_fu) begin errors++; $display("FAIL rand_fu cyc=%0d got=%h exp=%h", cyc, fu_bundle(), exp_fu); end
      step();
      // Model update for the edge just taken.
      if (flush) begin
        rs_q.delete();
      end else begin
        for (int i = 0; i < rs_q.size(); i++) begin
          if (cdb_valid && rs_q[i].w1 && rs_q[i].q1 == cdb_rob_tag) begin rs_q[i].v1 = cdb_data; rs_q[i].w1 = 0; end
          if (cdb_valid && rs_q[i].w2 && rs_q[i].q2 == cdb_rob_tag) begin rs_q[i].v2 = cdb_data; rs_q[i].w2 = 0; end
        end
        if (sel >= 0 && accept) rs_q.delete(sel);
        if (exp_dr && dispatch_valid) begin
          op.v1 = d_v1; op.v2 = d_v2; op.w1 = d_q1_wait; op.w2 = d_q2_wait; op.q1 = d_q1; op.q2 = d_q2;
          op.pc = d_pc; op.imm = d_immediate; op.pred = d_pred; op.tag = d_rob_tag; op.f3 = d_funct3;
          op.il = d_instruction_length; op.j = d_jalr; op.b = d_branch;
          if (op.w1 && cdb_valid && op.q1 == cdb_rob_tag) begin op.v1 = cdb_data; op.w1 = 0; end
          if (op.w2 && cdb_valid && op.q2 == cdb_rob_tag) begin op.v2 = cdb_data; op.w2 = 0; end
          rs_q.push_back(op);
        end
      end
    end
    flush = 1'b0; accept = 1'b0; drive_idle();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jalr_wakeup();
    test_age();
    test_dispatch_capture();
    test_full();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
